seq_shift_add_multiplier: RTL and testbench

//  Parametrised iterative unsigned multiplier: WIDTH x WIDTH -> 2*WIDTH product.

---
 rtl/seq_shift_add_multiplier.sv | 154 +++++++++++++++
 tb/tb_seq_shift_add_multiplier.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_shift_add_multiplier.sv
// seq_shift_add_multiplier
//   Iterative shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
//   One partial product per clock. Valid/ready handshakes on both sides.
//   FSM: IDLE (accept operands) -> BUSY (WIDTH iterations) -> DONE (hold result).
//   Optional macro MULT_SIGNED_EN: operands and product are two's complement.
//   The datapath multiplies magnitudes and negates the result when the operand
//   signs differ. Without the macro the block is purely unsigned.
module seq_shift_add_multiplier #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  logic [1:0]           state_q,   state_d;
  logic                 in_ready_q, in_ready_d;
  logic [2*WIDTH-1:0]   acc_q,     acc_d;
  logic [2*WIDTH-1:0]   mcand_q,   mcand_d;
  logic [WIDTH-1:0]     mplier_q,  mplier_d;
  logic [CNT_W-1:0]     count_q,   count_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  // Operand magnitudes captured at acceptance, and the value loaded into
  // product on the final iteration.
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [2*WIDTH-1:0]   acc_sum;
  logic [2*WIDTH-1:0]   result;

`ifdef MULT_SIGNED_EN
  logic neg_q, neg_d;

  // Magnitudes and result sign. -2^(W-1) negates to 2^(W-1), which still fits
  // in WIDTH bits when read as unsigned, so the most negative operand is exact.
  always_comb begin
    a_mag  = a[WIDTH-1] ? (~a + 1'b1) : a;
    b_mag  = b[WIDTH-1] ? (~b + 1'b1) : b;
    result = neg_q ? (~acc_sum + 1'b1) : acc_sum;
  end
`else
  // Unsigned build: operands go straight into the datapath.
  always_comb begin
    a_mag  = a;
    b_mag  = b;
    result = acc_sum;
  end
`endif

  // Partial-product add for the current iteration; 2*WIDTH bits cannot overflow.
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Next-state logic for the FSM and datapath.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    count_d   = count_q;
    product_d = product_q;
`ifdef MULT_SIGNED_EN
    neg_d     = neg_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        // in_ready_q is only set while idle, so it alone qualifies the accept.
        if (in_ready_q && in_valid) begin
          mcand_d  = {{WIDTH{1'b0}}, a_mag};
          mplier_d = b_mag;
          acc_d    = '0;
          count_d  = '0;
`ifdef MULT_SIGNED_EN
          neg_d    = a[WIDTH-1] ^ b[WIDTH-1];
`endif
          state_d  = S_BUSY;
        end
      end
      S_BUSY: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + 1'b1;
        if (count_q == LAST_ITER) begin
          product_d = result;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Registered so in_ready stays low during reset and rises on the first edge
    // after it; this also produces the one-cycle bubble after the output handshake.
    in_ready_d = (state_d == S_IDLE);
  end

  // State and datapath registers.
  // NOTE: reset is asynchronous (in the sensitivity list) so an abort clears the
  // outputs immediately, without waiting for a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      in_ready_q <= 1'b0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      count_q    <= '0;
      product_q  <= '0;
`ifdef MULT_SIGNED_EN
      neg_q      <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, regardless of statement order.
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      count_q    <= count_d;
      product_q  <= product_d;
`ifdef MULT_SIGNED_EN
      neg_q      <= neg_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_BUSY);
  assign product   = product_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Testbench for seq_shift_add_multiplier: one WIDTH=2 and one WIDTH=8 instance
// on a shared clock and reset, checked against an arithmetic reference model.
// Honours MULT_SIGNED_EN in the same way as the design.
module tb_seq_shift_add_multiplier;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // WIDTH=2 instance
  logic       in_valid2, in_ready2, out_valid2, out_ready2, busy2;
  logic [1:0] a2, b2;
  logic [3:0] product2;

  // WIDTH=8 instance
  logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] product8;

  int checks   = 0;
  int failures = 0;

  seq_shift_add_multiplier #(.WIDTH(2)) dut2 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid2), .in_ready(in_ready2), .a(a2), .b(b2),
    .out_valid(out_valid2), .out_ready(out_ready2), .product(product2), .busy(busy2)
  );

  seq_shift_add_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
    .out_valid(out_valid8), .out_ready(out_ready8), .product(product8), .busy(busy8)
  );

  // Reference model: plain integer multiplication, truncated to 2*W bits.
  function automatic logic [15:0] model8(input logic [7:0] x, input logic [7:0] y);
`ifdef MULT_SIGNED_EN
    int sx, sy;
    sx = int'($signed(x));
    sy = int'($signed(y));
    return 16'(sx * sy);
`else
    int unsigned ux, uy;
    ux = x;
    uy = y;
    return 16'(ux * uy);
`endif
  endfunction

  function automatic logic [3:0] model2(input logic [1:0] x, input logic [1:0] y);
`ifdef MULT_SIGNED_EN
    int sx, sy;
    sx = int'($signed(x));
    sy = int'($signed(y));
    return 4'(sx * sy);
`else
    int unsigned ux, uy;
    ux = x;
    uy = y;
    return 4'(ux * uy);
`endif
  endfunction

  // One W=8 transaction. Operands and in_valid are scrambled while the block
  // is busy or stalled; stall = cycles out_ready stays low after out_valid.
  task automatic op8(input logic [7:0] x, input logic [7:0] y, input int stall,
                     output logic [15:0] got, output int lat);
    int guard = 0;
    while (!in_ready8 && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    if (!in_ready8) begin
      checks++; failures++;
      $display("FAIL op8_wait_in_ready: in_ready=%b required 1", in_ready8);
    end
    a8 = x; b8 = y; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    lat = 0;
    while (!out_valid8 && lat < 100) begin
      checks++;
      if (busy8 !== 1'b1 || in_ready8 !== 1'b0) begin
        failures++;
        $display("FAIL op8_busy_flags: busy=%b in_ready=%b required busy=1 in_ready=0", busy8, in_ready8);
      end
      a8 = 8'($urandom); b8 = 8'($urandom); in_valid8 = 1'($urandom_range(0, 1));
      @(posedge clk); #1; lat++;
    end
    got = product8;
    for (int i = 0; i < stall; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); in_valid8 = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      checks++;
      if (product8 !== got || out_valid8 !== 1'b1 || in_ready8 !== 1'b0) begin
        failures++;
        $display("FAIL op8_stall cycle %0d: product=%h out_valid=%b in_ready=%b required product=%h out_valid=1 in_ready=0",
                 i, product8, out_valid8, in_ready8, got);
      end
    end
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    checks++;
    if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
      failures++;
      $display("FAIL op8_after_handshake: out_valid=%b in_ready=%b required out_valid=0 in_ready=1",
               out_valid8, in_ready8);
    end
  endtask

  // One W=2 transaction with out_ready asserted as soon as the result appears.
  task automatic op2(input logic [1:0] x, input logic [1:0] y,
                     output logic [3:0] got, output int lat);
    int guard = 0;
    while (!in_ready2 && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    a2 = x; b2 = y; in_valid2 = 1'b1;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    lat = 0;
    while (!out_valid2 && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    got = product2;
    out_ready2 = 1'b1;
    @(posedge clk); #1;
    out_ready2 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid2 = 1'b0; out_ready2 = 1'b0; a2 = '0; b2 = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready8 !== 1'b0 || out_valid8 !== 1'b0 || busy8 !== 1'b0 || product8 !== 16'h0) begin
      failures++;
      $display("FAIL reset_w8: in_ready=%b out_valid=%b busy=%b product=%h required all 0",
               in_ready8, out_valid8, busy8, product8);
    end
    checks++;
    if (in_ready2 !== 1'b0 || out_valid2 !== 1'b0 || busy2 !== 1'b0 || product2 !== 4'h0) begin
      failures++;
      $display("FAIL reset_w2: in_ready=%b out_valid=%b busy=%b product=%h required all 0",
               in_ready2, out_valid2, busy2, product2);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready8 !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_no_edge: in_ready=%b required 0", in_ready8);
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready8 !== 1'b1 || in_ready2 !== 1'b1) begin
      failures++;
      $display("FAIL reset_first_edge: in_ready8=%b in_ready2=%b required 1 1", in_ready8, in_ready2);
    end
  endtask

  task automatic test_w2_exhaustive();
    logic [3:0] got;
    int lat;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        op2(2'(i), 2'(j), got, lat);
        checks++;
        if (got !== model2(2'(i), 2'(j)) || lat != 2) begin
          failures++;
          $display("FAIL w2_pair %0d*%0d: product=%h latency=%0d required product=%h latency=2",
                   i, j, got, lat, model2(2'(i), 2'(j)));
        end
`ifndef MULT_SIGNED_EN
        if (i == 3 && j == 3) begin
          checks++;
          if (got !== 4'b1001) begin
            failures++;
            $display("FAIL w2_3x3: product=%b required 1001", got);
          end
        end
`endif
      end
    end
  endtask

  typedef struct {
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] exp;
  } corner_t;

  task automatic test_w8_corners();
    corner_t tbl[6];
    logic [15:0] got;
    int lat;
`ifdef MULT_SIGNED_EN
    tbl[0] = '{8'hFF, 8'hFF, 16'h0001};
    tbl[1] = '{8'h00, 8'hA5, 16'h0000};
    tbl[2] = '{8'h80, 8'h80, 16'h4000};
    tbl[3] = '{8'hFD, 8'h05, 16'hFFF1};
    tbl[4] = '{8'h7F, 8'hFF, 16'hFF81};
    tbl[5] = '{8'h01, 8'h01, 16'h0001};
`else
    tbl[0] = '{8'hFF, 8'hFF, 16'hFE01};
    tbl[1] = '{8'h00, 8'hA5, 16'h0000};
    tbl[2] = '{8'h80, 8'h80, 16'h4000};
    tbl[3] = '{8'hFD, 8'h05, 16'h04F1};
    tbl[4] = '{8'h7F, 8'hFF, 16'h7E81};
    tbl[5] = '{8'h01, 8'h01, 16'h0001};
`endif
    foreach (tbl[k]) begin
      op8(tbl[k].x, tbl[k].y, 0, got, lat);
      checks++;
      if (got !== tbl[k].exp || lat != 8) begin
        failures++;
        $display("FAIL w8_corner %h*%h: product=%h latency=%0d required product=%h latency=8",
                 tbl[k].x, tbl[k].y, got, lat, tbl[k].exp);
      end
    end
  endtask

  task automatic test_w8_random();
    logic [7:0]  x, y;
    logic [15:0] got;
    int lat;
    for (int k = 0; k < 30; k++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      op8(x, y, $urandom_range(0, 3), got, lat);
      checks++;
      if (got !== model8(x, y) || lat != 8) begin
        failures++;
        $display("FAIL w8_random %h*%h: product=%h latency=%0d required product=%h latency=8",
                 x, y, got, lat, model8(x, y));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0]  x, y;
    logic [15:0] got;
    int lat;
    x = 8'($urandom_range(1, 255));
    y = 8'($urandom_range(1, 255));
    op8(x, y, 20, got, lat);
    checks++;
    if (got !== model8(x, y)) begin
      failures++;
      $display("FAIL backpressure %h*%h: product=%h required %h", x, y, got, model8(x, y));
    end
  endtask

  // Operands held valid and out_ready high: accepts must be WIDTH+2 cycles apart.
  task automatic test_back_to_back();
    int prev = -1;
    int naccept = 0;
    int guard = 0;
    logic [7:0] x, y;
    x = 8'($urandom);
    y = 8'($urandom);
    a8 = x; b8 = y; in_valid8 = 1'b1; out_ready8 = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (in_ready8) begin
        if (prev >= 0) begin
          checks++;
          if (cyc - prev != 10) begin
            failures++;
            $display("FAIL back_to_back_interval: interval=%0d required 10", cyc - prev);
          end
        end
        prev = cyc;
        naccept++;
      end
      if (out_valid8) begin
        checks++;
        if (product8 !== model8(x, y)) begin
          failures++;
          $display("FAIL back_to_back_product: product=%h required %h", product8, model8(x, y));
        end
      end
      @(posedge clk); #1;
    end
    in_valid8 = 1'b0;
    checks++;
    if (naccept < 3) begin
      failures++;
      $display("FAIL back_to_back_accepts: accepts=%0d required at least 3", naccept);
    end
    while (!in_ready8 && guard < 30) begin
      @(posedge clk); #1; guard++;
    end
    out_ready8 = 1'b0;
  endtask

  task automatic test_reset_mid_busy();
    logic [15:0] got;
    int lat;
    int guard = 0;
    // Leave a non-zero result in the output register first.
    op8(8'd3, 8'd7, 0, got, lat);
    while (!in_ready8 && guard < 30) begin
      @(posedge clk); #1; guard++;
    end
    a8 = 8'hB7; b8 = 8'h5D; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid8 !== 1'b0 || product8 !== 16'h0 || busy8 !== 1'b0 || in_ready8 !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_busy: out_valid=%b product=%h busy=%b in_ready=%b required all 0",
               out_valid8, product8, busy8, in_ready8);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    op8(8'd12, 8'd10, 0, got, lat);
    checks++;
    if (got !== 16'd120 || lat != 8) begin
      failures++;
      $display("FAIL after_reset_12x10: product=%0d latency=%0d required product=120 latency=8", got, lat);
    end
  endtask

  initial begin
    test_reset();
    test_w2_exhaustive();
    test_w8_corners();
    test_w8_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
